product_mem_responder: RTL

- Memory responder at the far end of the multiplier's write and read-back ports: a DEPTH x WIDTH result buffer.
- Accepts product writes (EN_writeMem/writeMem_addr/writeMem_val) and answers reads (EN_readMem/readMem_addr) with registered readMem_val.
- Tracks fill/drain occupancy and exposes status flags for the block-read sequencer.

---
 rtl/product_mem_pkg.sv | 13 +
 rtl/product_mem_array.sv | 29 ++
 rtl/product_mem_responder.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/product_mem_pkg.sv
// Shared state type and default geometry for the product result buffer.
package product_mem_pkg;

  typedef enum logic [1:0] {
    FILL,
    FULL,
    DRAIN
  } mem_state_t;

  localparam int DEFAULT_LOGDEPTH = 6;
  localparam int DEFAULT_WIDTH    = 32;

endpackage

// File: rtl/product_mem_array.sv
// Plain 1R1W synchronous-read RAM, read-first on an address collision.
module product_mem_array
  import product_mem_pkg::*;
#(
  parameter int LOGDEPTH = DEFAULT_LOGDEPTH,
  parameter int WIDTH    = DEFAULT_WIDTH
) (
  input  logic                clk,
  input  logic                we,
  input  logic [LOGDEPTH-1:0] waddr,
  input  logic [WIDTH-1:0]    wdata,
  input  logic                re,
  input  logic [LOGDEPTH-1:0] raddr,
  output logic [WIDTH-1:0]    rdata
);

  logic [WIDTH-1:0] mem_q [2**LOGDEPTH];
  logic [WIDTH-1:0] rdata_q;

  // NOTE: the storage has no reset so it maps onto block RAM; the owner masks never-written entries.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
    // NOTE: non-blocking write and read in one process return the old word on a same-address hit.
    if (re) rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/product_mem_responder.sv
// Result buffer responder: fill/full/drain occupancy FSM around a 1R1W RAM.
// Optional per-entry even parity when PRODUCT_MEM_PARITY_EN is defined.
module product_mem_responder
  import product_mem_pkg::*;
#(
  parameter int LOGDEPTH = DEFAULT_LOGDEPTH,
  parameter int WIDTH    = DEFAULT_WIDTH
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                EN_writeMem,
  input  logic [LOGDEPTH-1:0] writeMem_addr,
  input  logic [WIDTH-1:0]    writeMem_val,
  input  logic                EN_readMem,
  input  logic [LOGDEPTH-1:0] readMem_addr,
  output logic [WIDTH-1:0]    readMem_val,
  output logic                readMem_valid,
  output logic                mem_full,
  output logic                mem_drained,
  output logic [LOGDEPTH:0]   wr_count,
  output logic                err_overflow,
  output logic                err_unwritten
`ifdef PRODUCT_MEM_PARITY_EN
  ,
  input  logic                par_inject,
  output logic                par_err
`endif
);

  localparam int DEPTH = 2**LOGDEPTH;
  localparam logic [LOGDEPTH:0] CNT_MAX = (LOGDEPTH+1)'(DEPTH);
  localparam logic [LOGDEPTH:0] CNT_ONE = (LOGDEPTH+1)'(1);
`ifdef PRODUCT_MEM_PARITY_EN
  localparam int RAM_W = WIDTH + 1;
`else
  localparam int RAM_W = WIDTH;
`endif

  mem_state_t         state_q, state_d;
  logic [DEPTH-1:0]   valid_q, valid_d;
  logic [DEPTH-1:0]   rd_q, rd_d;
  logic [LOGDEPTH:0]  wr_count_q, wr_count_d;
  logic [LOGDEPTH:0]  rd_count_q, rd_count_d;
  logic               mem_full_q, mem_full_d;
  logic               mem_drained_q, mem_drained_d;
  logic               rd_valid_q, rd_valid_d;
  logic               rd_zero_q, rd_zero_d;
  logic               err_overflow_q, err_overflow_d;
  logic               err_unwritten_q, err_unwritten_d;
  logic               ram_we;
  logic [RAM_W-1:0]   ram_wdata;
  logic [RAM_W-1:0]   ram_rdata;

`ifdef PRODUCT_MEM_PARITY_EN
  // Stored bit makes the entry even parity; the hook corrupts it for fault injection.
  assign ram_wdata = {(^writeMem_val) ^ par_inject, writeMem_val};
  assign par_err   = rd_valid_q & ~rd_zero_q & (^ram_rdata);
`else
  assign ram_wdata = writeMem_val;
`endif

  product_mem_array #(
    .LOGDEPTH (LOGDEPTH),
    .WIDTH    (RAM_W)
  ) u_array (
    .clk   (clk),
    .we    (ram_we),
    .waddr (writeMem_addr),
    .wdata (ram_wdata),
    .re    (EN_readMem & ~rst),
    .raddr (readMem_addr),
    .rdata (ram_rdata)
  );

  always_comb begin
    // NOTE: every signal written here gets its default first, so no path can infer a latch.
    state_d         = state_q;
    valid_d         = valid_q;
    rd_d            = rd_q;
    wr_count_d      = wr_count_q;
    rd_count_d      = rd_count_q;
    mem_full_d      = mem_full_q;
    mem_drained_d   = 1'b0;
    rd_valid_d      = EN_readMem;
    rd_zero_d       = rd_zero_q;
    err_overflow_d  = err_overflow_q;
    err_unwritten_d = err_unwritten_q;
    ram_we          = 1'b0;

    // Validity is judged before this cycle's write, matching the RAM's read-first data.
    if (EN_readMem) begin
      rd_zero_d = ~valid_q[readMem_addr];
      if (!valid_q[readMem_addr]) err_unwritten_d = 1'b1;
    end

    unique case (state_q)
      FILL: begin
        if (EN_writeMem) begin
          ram_we                 = 1'b1;
          valid_d[writeMem_addr] = 1'b1;
          if (!valid_q[writeMem_addr] && wr_count_q != CNT_MAX) begin
            wr_count_d = wr_count_q + CNT_ONE;
          end
          if (wr_count_d == CNT_MAX) begin
            state_d    = FULL;
            mem_full_d = 1'b1;
          end
        end
      end
      FULL, DRAIN: begin
        if (EN_writeMem) err_overflow_d = 1'b1;
        if (EN_readMem) begin
          state_d = DRAIN;
          if (!rd_q[readMem_addr]) begin
            rd_d[readMem_addr] = 1'b1;
            rd_count_d         = rd_count_q + CNT_ONE;
          end
          if (rd_count_d == CNT_MAX) begin
            mem_drained_d = 1'b1;
            valid_d       = '0;
            rd_d          = '0;
            wr_count_d    = '0;
            rd_count_d    = '0;
            mem_full_d    = 1'b0;
            state_d       = FILL;
          end
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= FILL;
      valid_q         <= '0;
      rd_q            <= '0;
      wr_count_q      <= '0;
      rd_count_q      <= '0;
      mem_full_q      <= 1'b0;
      mem_drained_q   <= 1'b0;
      rd_valid_q      <= 1'b0;
      rd_zero_q       <= 1'b1;
      err_overflow_q  <= 1'b0;
      err_unwritten_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      valid_q         <= valid_d;
      rd_q            <= rd_d;
      wr_count_q      <= wr_count_d;
      rd_count_q      <= rd_count_d;
      mem_full_q      <= mem_full_d;
      mem_drained_q   <= mem_drained_d;
      rd_valid_q      <= rd_valid_d;
      rd_zero_q       <= rd_zero_d;
      err_overflow_q  <= err_overflow_d;
      err_unwritten_q <= err_unwritten_d;
    end
  end

  // A never-written read, and the reset state, present zero instead of raw RAM output.
  assign readMem_val   = rd_zero_q ? '0 : ram_rdata[WIDTH-1:0];
  assign readMem_valid = rd_valid_q;
  assign mem_full      = mem_full_q;
  assign mem_drained   = mem_drained_q;
  assign wr_count      = wr_count_q;
  assign err_overflow  = err_overflow_q;
  assign err_unwritten = err_unwritten_q;

endmodule
